// File: rtl/sha_rd_arbiter.sv
// Round-robin AR arbiter sharing one AXI4 read channel among NUM_REQ SHA engines.
// The requester index is tagged into ARID and R beats are steered back by RID.
module sha_rd_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int IN_ID_W  = 4,
  parameter int OUT_ID_W = 16,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int MAX_OUT  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          arvalid_s,
  output logic [NUM_REQ-1:0]          arready_s,
  input  logic [NUM_REQ*ADDR_W-1:0]   araddr_s,
  input  logic [NUM_REQ*IN_ID_W-1:0]  arid_s,
  input  logic [NUM_REQ*8-1:0]        arlen_s,
  input  logic [NUM_REQ*3-1:0]        arsize_s,
  output logic [NUM_REQ-1:0]          rvalid_s,
  input  logic [NUM_REQ-1:0]          rready_s,
  output logic [DATA_W-1:0]           rdata_s,
  output logic [IN_ID_W-1:0]          rid_s,
  output logic [1:0]                  rresp_s,
  output logic                        rlast_s,
  output logic                        arvalid_m,
  input  logic                        arready_m,
  output logic [ADDR_W-1:0]           araddr_m,
  output logic [OUT_ID_W-1:0]         arid_m,
  output logic [7:0]                  arlen_m,
  output logic [2:0]                  arsize_m,
  input  logic                        rvalid_m,
  output logic                        rready_m,
  input  logic [DATA_W-1:0]           rdata_m,
  input  logic [OUT_ID_W-1:0]         rid_m,
  input  logic [1:0]                  rresp_m,
  input  logic                        rlast_m,
  output logic                        err_rid
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic                r_hold_v;
  logic [IDX_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_cnt [NUM_REQ];
  logic                r_err;

  logic                w_load;
  logic                w_any;
  logic [IDX_W-1:0]    w_win;
  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_inc;
  logic [NUM_REQ-1:0]  w_dec;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [IN_ID_W-1:0]  w_sel_id;
  logic [7:0]          w_sel_len;
  logic [2:0]          w_sel_size;
  logic [IDX_W-1:0]    w_ridx;
  logic                w_rbad;
  int                  w_j;

  assign w_load    = !r_hold_v || arready_m;
  assign arvalid_m = r_hold_v;
  assign err_rid   = r_err;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_elig[i] = arvalid_s[i] && (r_cnt[i] != CNT_W'(MAX_OUT));
  end

  // Scan from the pointer with wrap-around; first eligible requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
      if (!w_any && w_elig[w_j]) begin
        w_any = 1'b1;
        w_win = IDX_W'(w_j);
      end
    end
  end

  always_comb begin
    arready_s  = '0;
    w_sel_addr = '0;
    w_sel_id   = '0;
    w_sel_len  = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arready_s[i] = w_load && w_any && (w_win == IDX_W'(i));
      if (w_win == IDX_W'(i)) begin
        w_sel_addr = araddr_s[i*ADDR_W +: ADDR_W];
        w_sel_id   = arid_s[i*IN_ID_W +: IN_ID_W];
        w_sel_len  = arlen_s[i*8 +: 8];
        w_sel_size = arsize_s[i*3 +: 3];
      end
    end
  end

  // AR holding register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_v <= 1'b0;
      r_ptr    <= '0;
      araddr_m <= '0;
      arid_m   <= '0;
      arlen_m  <= '0;
      arsize_m <= '0;
    end else if (w_load) begin
      r_hold_v <= w_any;
      if (w_any) begin
        araddr_m <= w_sel_addr;
        arid_m   <= OUT_ID_W'({w_win, w_sel_id});
        arlen_m  <= w_sel_len;
        arsize_m <= w_sel_size;
        r_ptr    <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end
    end
  end

  // R path: pure combinational steering by the RID index field
  assign w_ridx  = rid_m[IN_ID_W +: IDX_W];
  assign w_rbad  = ({1'b0, w_ridx} > (IDX_W + 1)'(NUM_REQ - 1));
  assign rdata_s = rdata_m;
  assign rresp_s = rresp_m;
  assign rlast_s = rlast_m;
  assign rid_s   = rid_m[IN_ID_W-1:0];

  always_comb begin
    rready_m = w_rbad;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_s[i] = rvalid_m && (w_ridx == IDX_W'(i));
      if (w_ridx == IDX_W'(i)) rready_m = rready_s[i];
    end
  end

  generate
    if (OUT_ID_W > IN_ID_W + IDX_W) begin : g_rid_pad
      logic w_unused_rid;
      assign w_unused_rid = ^rid_m[OUT_ID_W-1:IN_ID_W+IDX_W];
    end
  endgenerate

  // Decrement is gated on a nonzero count so beats for pre-reset bursts cannot underflow.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_inc[i] = arvalid_s[i] && arready_s[i];
      w_dec[i] = rvalid_m && rready_m && rlast_m && !w_rbad &&
                 (w_ridx == IDX_W'(i)) && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      if (rvalid_m && w_rbad) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha_rd_arbiter.sv
// Directed bench for sha_rd_arbiter; IDX_W=3 so out-of-range RID indices are representable.
module tb_sha_rd_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int IDX_W    = 3;
  localparam int IN_ID_W  = 4;
  localparam int OUT_ID_W = 16;
  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 512;
  localparam int MAX_OUT  = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          arvalid_s;
  logic [NUM_REQ-1:0]          arready_s;
  logic [NUM_REQ*ADDR_W-1:0]   araddr_s;
  logic [NUM_REQ*IN_ID_W-1:0]  arid_s;
  logic [NUM_REQ*8-1:0]        arlen_s;
  logic [NUM_REQ*3-1:0]        arsize_s;
  logic [NUM_REQ-1:0]          rvalid_s;
  logic [NUM_REQ-1:0]          rready_s;
  logic [DATA_W-1:0]           rdata_s;
  logic [IN_ID_W-1:0]          rid_s;
  logic [1:0]                  rresp_s;
  logic                        rlast_s;
  logic                        arvalid_m;
  logic                        arready_m;
  logic [ADDR_W-1:0]           araddr_m;
  logic [OUT_ID_W-1:0]         arid_m;
  logic [7:0]                  arlen_m;
  logic [2:0]                  arsize_m;
  logic                        rvalid_m;
  logic                        rready_m;
  logic [DATA_W-1:0]           rdata_m;
  logic [OUT_ID_W-1:0]         rid_m;
  logic [1:0]                  rresp_m;
  logic                        rlast_m;
  logic                        err_rid;

  int n_chk  = 0;
  int n_pass = 0;

  sha_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid_s(arvalid_s), .arready_s(arready_s), .araddr_s(araddr_s),
    .arid_s(arid_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s), .rdata_s(rdata_s),
    .rid_s(rid_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
    .arvalid_m(arvalid_m), .arready_m(arready_m), .araddr_m(araddr_m),
    .arid_m(arid_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m), .rdata_m(rdata_m),
    .rid_m(rid_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .err_rid(err_rid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic set_req(input int i, input logic [63:0] addr, input logic [3:0] id,
                         input logic [7:0] len);
    araddr_s[i*ADDR_W +: ADDR_W] = addr;
    arid_s[i*IN_ID_W +: IN_ID_W] = id;
    arlen_s[i*8 +: 8]            = len;
    arsize_s[i*3 +: 3]           = 3'd6;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arvalid_s = '0; araddr_s = '0; arid_s = '0; arlen_s = '0; arsize_s = '0;
    rready_s = '0; arready_m = 1'b0; rvalid_m = 1'b0; rdata_m = '0;
    rid_m = '0; rresp_m = '0; rlast_m = 1'b0;
    #1;
    chk("rst_arvalid_m", 64'(arvalid_m), 64'd0);
    chk("rst_araddr_m", araddr_m, 64'd0);
    chk("rst_arid_m", 64'(arid_m), 64'd0);
    chk("rst_err_rid", 64'(err_rid), 64'd0);
    chk("rst_arready_s", 64'(arready_s), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 2 and its four-beat return
    @(negedge clk);
    set_req(2, 64'h1000, 4'h5, 8'd3);
    arvalid_s = 4'b0100; arready_m = 1'b1;
    #1 chk("single_arready", 64'(arready_s), 64'b0100);
    @(negedge clk);
    arvalid_s = '0;
    #1;
    chk("single_arready_drop", 64'(arready_s), 64'd0);
    chk("single_arvalid_m", 64'(arvalid_m), 64'd1);
    chk("single_arid_m", 64'(arid_m), 64'h0025);
    chk("single_araddr_m", araddr_m, 64'h1000);
    chk("single_arlen_m", 64'(arlen_m), 64'd3);
    @(negedge clk);
    chk("single_arvalid_off", 64'(arvalid_m), 64'd0);
    chk("single_cnt_one", 64'(dut.r_cnt[2]), 64'd1);
    rvalid_m = 1'b1; rid_m = 16'h0025; rready_s = 4'b0000; rdata_m = '0;
    #1 chk("r_stall_rready_m", 64'(rready_m), 64'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      rready_s = 4'b0100; rlast_m = (b == 3); rdata_m = DATA_W'(b + 16'hA0);
      #1;
      chk("r_rvalid_s", 64'(rvalid_s), 64'b0100);
      chk("r_rid_s", 64'(rid_s), 64'h5);
      chk("r_rdata_s", rdata_s[63:0], 64'(b + 16'hA0));
      chk("r_rready_m", 64'(rready_m), 64'd1);
    end
    @(negedge clk);
    rvalid_m = 1'b0; rlast_m = 1'b0; rready_s = '0;
    #1 chk("single_cnt_zero", 64'(dut.r_cnt[2]), 64'd0);

    // Fairness with all four requesters continuously valid
    pulse_rst();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(32'h2000 + i * 32'h100), 4'(i + 8), 8'd0);
    @(negedge clk);
    arvalid_s = 4'b1111; arready_m = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 64'(arready_s), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("rr_arvalid_m", 64'(arvalid_m), 64'd1);
        chk("rr_arid_m", 64'(arid_m), 64'((((k - 1) % 4) << 4) | (((k - 1) % 4) + 8)));
      end
      @(negedge clk);
    end
    arvalid_s = '0;

    // Backpressure: held request stays stable, next grant coincides with acceptance
    pulse_rst();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(32'h1000 + i * 32'h100), 4'(i), 8'd7);
    @(negedge clk);
    arready_m = 1'b0; arvalid_s = 4'b0011;
    #1 chk("bp_first_grant", 64'(arready_s), 64'b0001);
    @(negedge clk);
    arvalid_s = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_arvalid_m", 64'(arvalid_m), 64'd1);
      chk("bp_araddr_m", araddr_m, 64'h1000);
      chk("bp_arready_s", 64'(arready_s), 64'd0);
      @(negedge clk);
    end
    arready_m = 1'b1;
    #1 chk("bp_release_grant", 64'(arready_s), 64'b0010);
    @(negedge clk);
    arvalid_s = '0;
    #1;
    chk("bp_next_araddr", araddr_m, 64'h1100);
    chk("bp_next_arid", 64'(arid_m), 64'h0011);

    // Outstanding limit on requester 0
    pulse_rst();
    @(negedge clk);
    arvalid_s = 4'b0001; arready_m = 1'b1;
    for (int n = 0; n < MAX_OUT; n++) begin
      #1 chk("lim_grant", 64'(arready_s), 64'b0001);
      @(negedge clk);
    end
    #1 chk("lim_blocked", 64'(arready_s), 64'd0);
    arvalid_s = 4'b0011;
    #1 chk("lim_other_served", 64'(arready_s), 64'b0010);
    @(negedge clk);
    arvalid_s = 4'b0001;
    rvalid_m = 1'b1; rid_m = 16'h0000; rlast_m = 1'b1; rready_s = 4'b0001;
    #1;
    chk("lim_still_blocked", 64'(arready_s), 64'd0);
    chk("lim_rvalid_s", 64'(rvalid_s), 64'b0001);
    @(negedge clk);
    rvalid_m = 1'b0; rlast_m = 1'b0; rready_s = '0;
    #1 chk("lim_ninth_grant", 64'(arready_s), 64'b0001);
    @(negedge clk);
    arvalid_s = '0;
    #1 chk("lim_cnt_full", 64'(dut.r_cnt[0]), 64'd8);

    // Out-of-range RID index
    rvalid_m = 1'b1; rid_m = 16'h0060; rlast_m = 1'b1; rready_s = '0;
    #1;
    chk("bad_rready_m", 64'(rready_m), 64'd1);
    chk("bad_rvalid_s", 64'(rvalid_s), 64'd0);
    @(negedge clk);
    rvalid_m = 1'b0; rlast_m = 1'b0;
    #1 chk("bad_err_set", 64'(err_rid), 64'd1);
    chk("bad_cnt_kept", 64'(dut.r_cnt[0]), 64'd8);
    @(negedge clk);
    #1 chk("bad_err_sticky", 64'(err_rid), 64'd1);

    // Asynchronous reset with a held request and two bursts outstanding on requester 3
    @(negedge clk);
    arvalid_s = 4'b1000; arready_m = 1'b1;
    #1 chk("ar3_grant", 64'(arready_s), 64'b1000);
    @(negedge clk);
    @(negedge clk);
    arvalid_s = '0; arready_m = 1'b0;
    #1;
    chk("ar3_held", 64'(arvalid_m), 64'd1);
    chk("ar3_cnt", 64'(dut.r_cnt[3]), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_arvalid_m", 64'(arvalid_m), 64'd0);
    chk("arst_cnt3", 64'(dut.r_cnt[3]), 64'd0);
    chk("arst_cnt0", 64'(dut.r_cnt[0]), 64'd0);
    chk("arst_err", 64'(err_rid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    rvalid_m = 1'b1; rid_m = 16'h0030; rlast_m = 1'b1; rready_s = 4'b1000;
    #1 chk("post_rst_route", 64'(rvalid_s), 64'b1000);
    @(negedge clk);
    rvalid_m = 1'b0; rlast_m = 1'b0; rready_s = '0;
    #1 chk("post_rst_no_underflow", 64'(dut.r_cnt[3]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
